// File: rtl/hc16x_counter_pkg.sv
// Shared definitions for the cascaded 74HC160/163-style counter.
// The priority decode is shared so slices and any model agree on the ordering.
package hc_pkg;

   localparam int NIB = 4;
   localparam logic [NIB-1:0] TC_BIN = 4'd15;
   localparam logic [NIB-1:0] TC_DEC = 4'd9;

   typedef enum logic [1:0] {
      CLR,
      LOAD,
      COUNT,
      HOLD
   } op_e;

   // Clear beats load, load beats count, and counting needs both enables.
   function automatic op_e decode_op(input logic clr_n, input logic load_n,
                                     input logic enp, input logic ent);
      if (!clr_n)
         return CLR;
      else if (!load_n)
         return LOAD;
      else if (enp && ent)
         return COUNT;
      else
         return HOLD;
   endfunction

endpackage

// File: rtl/hc16x_counter_if.sv
// Control/data bundle of the HC counter: load, enables, load data, state and carry.
interface hc16x_counter_if #(parameter int W = 8) ();

   logic         LOAD_N;
   logic         ENP;
   logic         ENT;
   logic [W:1]   D;
   logic [W:1]   Q;
   logic         RCO;

   modport master (output LOAD_N, ENP, ENT, D, input Q, RCO);
   modport slave  (input LOAD_N, ENP, ENT, D, output Q, RCO);

endinterface

// File: rtl/hc16x_counter_slice.sv
// One 4-bit 160/163 slice: sync clear, sync load, enabled count, combinational RCO.
module hc16x_slice
   import hc_pkg::*;
#(
   parameter int DECADE = 0
) (
   input  logic         CLK,
   input  logic         CLR_N,
   input  logic         LOAD_N,
   input  logic         ENP,
   input  logic         ENT,
   input  logic [4:1]   D,
   output logic [4:1]   Q,
   output logic         RCO
);

   localparam logic [NIB-1:0] TC = (DECADE != 0) ? TC_DEC : TC_BIN;

   op_e op;

   always_comb begin
      op = decode_op(CLR_N, LOAD_N, ENP, ENT);
   end

   // Out-of-range decade values (10-15) fall back to zero on their next count.
   always_ff @(posedge CLK) begin
      if (!CLR_N) begin
         Q <= '0;
      end else begin
         unique case (op)
            LOAD:    Q <= D;
            COUNT:   Q <= (Q >= TC) ? 4'd0 : Q + 4'd1;
            default: Q <= Q;
         endcase
      end
   end

   assign RCO = ENT && (Q == TC);

endmodule

// File: rtl/hc16x_counter.sv
// Presettable counter of STAGES cascaded slices using the ENP/ENT/RCO look-ahead chain.
module hc16x_counter
   import hc_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int DECADE = 0
) (
   input  logic              CLK,
   input  logic              CLR_N,
   hc16x_counter_if.slave    bus
);

   localparam int W = NIB * STAGES;

   logic [STAGES:0] ent_chain;
   logic [W:1]      q_all;

   assign ent_chain[0] = bus.ENT;

   // Each slice's RCO becomes the next slice's ENT; ENP fans out to all of them.
   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      hc16x_slice #(
         .DECADE (DECADE)
      ) u_slice (
         .CLK    (CLK),
         .CLR_N  (CLR_N),
         .LOAD_N (bus.LOAD_N),
         .ENP    (bus.ENP),
         .ENT    (ent_chain[k]),
         .D      (bus.D[NIB*k+NIB:NIB*k+1]),
         .Q      (q_all[NIB*k+NIB:NIB*k+1]),
         .RCO    (ent_chain[k+1])
      );
   end

   assign bus.Q   = q_all;
   assign bus.RCO = ent_chain[STAGES];

endmodule

// File: tb/tb_hc16x_counter.sv
// Scoreboard bench: six counter configurations share one random/directed stimulus stream.
module tb_hc16x_counter;
   import hc_pkg::*;

   localparam int NCFG = 6;

   typedef struct {
      logic [NCFG-1:0][11:0] q;
      logic [NCFG-1:0]       rco;
      bit                    mvalid;
      bit                    dchk;
      int                    didx;
      logic [11:0]           dq;
      logic                  drco;
      string                 dname;
   } exp_t;

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   logic load_n = 1'b1;
   logic enp = 1'b0;
   logic ent = 1'b0;
   logic [11:0] d = '0;

   logic [NCFG-1:0][11:0] act_q;
   logic [NCFG-1:0]       act_rco;

   exp_t sb[$];
   logic [11:0] mq [NCFG];
   bit model_valid = 0;
   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Configs: 0/1 = 2 stages, 2/3 = 1 stage, 4/5 = 3 stages; odd ones are decade.
   function automatic int stages_of(input int i);
      return (i < 2) ? 2 : (i < 4) ? 1 : 3;
   endfunction

   function automatic bit decade_of(input int i);
      return (i % 2) == 1;
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int ST  = (g < 2) ? 2 : (g < 4) ? 1 : 3;
      localparam int DEC = g % 2;
      hc16x_counter_if #(.W(4*ST)) bus ();
      assign bus.LOAD_N = load_n;
      assign bus.ENP    = enp;
      assign bus.ENT    = ent;
      assign bus.D      = d[4*ST-1:0];
      hc16x_counter #(.STAGES(ST), .DECADE(DEC)) dut (
         .CLK   (clk),
         .CLR_N (clr_n),
         .bus   (bus)
      );
      assign act_q[g]   = 12'(bus.Q);
      assign act_rco[g] = bus.RCO;
   end

   // Counting treated as decimal/hex digits: a carry ripples only through digits at terminal count.
   function automatic logic [11:0] ref_next(input logic [11:0] q, input op_e op,
                                            input logic [11:0] din, input int st, input bit dec);
      int tc = dec ? 9 : 15;
      int mask = (1 << (4*st)) - 1;
      logic [11:0] r = q;
      bit carry = 1;
      int nib;
      case (op)
         CLR:  return '0;
         LOAD: return din & 12'(mask);
         COUNT: begin
            for (int k = 0; k < st; k++) begin
               if (carry) begin
                  nib = int'(q[4*k +: 4]);
                  r[4*k +: 4] = (nib >= tc) ? 4'd0 : 4'(nib + 1);
                  carry = (nib == tc);
               end
            end
            return r;
         end
         default: return q;
      endcase
   endfunction

   function automatic logic ref_rco(input logic [11:0] q, input logic en,
                                    input int st, input bit dec);
      int tc = dec ? 9 : 15;
      if (!en) return 1'b0;
      for (int k = 0; k < st; k++)
         if (int'(q[4*k +: 4]) != tc) return 1'b0;
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic [11:0] actual,
                              input logic [11:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle; the pushed entry describes what the DUT shows during this cycle.
   task automatic applyStimulus(input logic c, input logic l, input logic p, input logic t,
                                input logic [11:0] din, input bit dchk = 0, input int didx = 0,
                                input logic [11:0] dq = '0, input logic drco = 1'b0,
                                input string dname = "");
      exp_t e;
      @(posedge clk);
      #1;
      clr_n = c; load_n = l; enp = p; ent = t; d = din;
      for (int i = 0; i < NCFG; i++) begin
         e.q[i]   = mq[i];
         e.rco[i] = ref_rco(mq[i], t, stages_of(i), decade_of(i));
      end
      e.mvalid = model_valid;
      e.dchk = dchk; e.didx = didx; e.dq = dq; e.drco = drco; e.dname = dname;
      sb.push_back(e);
      for (int i = 0; i < NCFG; i++)
         mq[i] = ref_next(mq[i], decode_op(c, l, p, t), din, stages_of(i), decade_of(i));
      if (!c) model_valid = 1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.mvalid) begin
               for (int i = 0; i < NCFG; i++) begin
                  checkOutput($sformatf("q_cfg%0d", i), act_q[i], e.q[i]);
                  checkOutput($sformatf("rco_cfg%0d", i), 12'(act_rco[i]), 12'(e.rco[i]));
               end
            end
            if (e.dchk) begin
               checkOutput({e.dname, "_q"}, act_q[e.didx], e.dq);
               checkOutput({e.dname, "_rco"}, 12'(act_rco[e.didx]), 12'(e.drco));
            end
         end
      end
   end

   initial begin : stimulus
      int budget;
      for (int i = 0; i < NCFG; i++) mq[i] = '0;

      applyStimulus(0, 1, 1, 1, 12'h000);
      applyStimulus(0, 1, 1, 1, 12'h000);
      applyStimulus(1, 1, 1, 1, 12'h000, 1, 0, 12'h000, 0, "reset");
      applyStimulus(1, 1, 1, 1, 12'h000);
      applyStimulus(1, 1, 1, 1, 12'h000);
      applyStimulus(1, 1, 0, 1, 12'h000, 1, 0, 12'h003, 0, "count3");

      applyStimulus(1, 0, 1, 1, 12'h00F);
      applyStimulus(1, 1, 1, 1, 12'h000, 1, 0, 12'h00F, 0, "load0f");
      applyStimulus(1, 0, 1, 1, 12'h0FF, 1, 0, 12'h010, 0, "carry10");
      applyStimulus(1, 1, 1, 1, 12'h000, 1, 0, 12'h0FF, 1, "rco_ff");
      applyStimulus(1, 1, 0, 1, 12'h000, 1, 0, 12'h000, 0, "wrap_bin");

      applyStimulus(1, 0, 0, 1, 12'h099);
      applyStimulus(1, 1, 1, 1, 12'h000, 1, 1, 12'h099, 1, "rco_99");
      applyStimulus(1, 0, 1, 1, 12'h00C, 1, 1, 12'h000, 0, "wrap_dec");
      applyStimulus(1, 1, 1, 1, 12'h000, 1, 1, 12'h00C, 0, "load0c");
      applyStimulus(1, 1, 0, 1, 12'h000, 1, 1, 12'h000, 0, "dec_oor");

      applyStimulus(1, 0, 0, 1, 12'h042);
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 1, 0, 1, 12'h000, 1, 0, 12'h042, 0, "hold42");
      applyStimulus(1, 0, 1, 1, 12'h05A, 1, 0, 12'h042, 0, "hold42");
      applyStimulus(1, 1, 0, 1, 12'h000, 1, 0, 12'h05A, 0, "load_wins");
      applyStimulus(0, 0, 1, 1, 12'h0FF, 1, 0, 12'h05A, 0, "pre_clr");
      applyStimulus(1, 1, 0, 1, 12'h000, 1, 0, 12'h000, 0, "clr_wins");

      applyStimulus(1, 0, 0, 1, 12'h07E);
      applyStimulus(1, 1, 1, 1, 12'h000, 1, 0, 12'h07E, 0, "run7e");
      applyStimulus(0, 1, 1, 1, 12'h000, 1, 0, 12'h07F, 0, "run7f");
      applyStimulus(1, 1, 0, 1, 12'h000, 1, 0, 12'h000, 0, "mid_clr");

      for (int n = 0; n < 10000; n++)
         applyStimulus(($urandom_range(15) != 0), ($urandom_range(7) != 0),
                       ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                       12'($urandom));

      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      if (sb.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
